dmem_resp: RTL
==============

Name: dmem_resp

Overview:
- Data-memory responder: the memory end of the CPU data-port interface (address, write data and write enable in; read data out), extended with a req/ack handshake and programmable wait states.
- Word-addressed synchronous RAM plus a memory-mapped completion register at DONE_ADDR and a free-running cycle counter, so benches and multicycle cores can detect program end without peeking into internals.
- Sits between a core's data port and the bench/top level.

Parameters:
- DATA_W, 32, data and address bus width.
- AW, 16, word-index bits; RAM depth 2**AW words; byte address bits [AW+1:2] used.
- WAIT_CYC, 2, wait states inserted before ack (0..15).
- DONE_ADDR, 32'h00000050, byte address of the completion register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request valid; held by initiator until ack.
- we  in  1  1=write, 0=read; qualified by req.
- addr  in  DATA_W  byte address.
- wdata  in  DATA_W  write data.
- ack  out  1  one-cycle response strobe.
- err  out  1  error flag, valid with ack.
- rdata  out  DATA_W  read data, valid with ack.
- done  out  1  sticky; set by a write to DONE_ADDR.
- done_data  out  DATA_W  wdata captured by the DONE_ADDR write.
- cyc_cnt  out  DATA_W  cycles since reset release; frozen once done=1.

Behaviour:
- Reset, asynchronous: state=IDLE, ack=0, err=0, rdata=0, done=0, done_data=0, cyc_cnt=0. RAM contents are not reset.
- FSM states IDLE, WAIT, RESP.
- IDLE: on req=1, latch addr, we and wdata, and load the wait counter with WAIT_CYC. Go to WAIT if WAIT_CYC>0, else to RESP.
- WAIT: decrement the counter each cycle. When it reaches 1, go to RESP.
- RESP: ack=1 for exactly one cycle, then return to IDLE.
- Latency: ack is high in cycle N+WAIT_CYC+1, where N is the accepting edge.
- req is ignored outside IDLE. After ack, a still-high req in IDLE is accepted as a new request, so the initiator must drop req in the ack cycle unless it is issuing back-to-back transfers.
- Throughput with back-to-back requests: one transfer per WAIT_CYC+2 cycles.
- Read: rdata=RAM[addr[AW+1:2]], registered on entry to RESP and held until the next response.
- Write: RAM written at the edge that enters RESP; rdata is unchanged by writes.
- Error: err=1 with ack when addr[1:0]!=0 or addr[DATA_W-1:AW+2]!=0.
  - No RAM write and no done update.
  - rdata=0.
  - err=0 on all other acks and when ack=0.
- Completion: a non-error write with addr==DONE_ADDR also writes RAM normally.
  - done set at the same edge as the RAM write; done_data=wdata at that edge.
  - Only the first DONE_ADDR write is captured; later ones update RAM only.
- Reads of DONE_ADDR return RAM contents.
- cyc_cnt: +1 every clock while done=0; wraps at 2**DATA_W. It holds on the same edge that sets done.
- Reset mid-transaction: the transfer is aborted. No ack is issued after reset release. A RAM write occurs only if its edge preceded the reset.

Optional Feature:
- Macro DMEM_BYTE_EN.
- Defined: adds port be (in, DATA_W/8) latched with the request. Writes update only byte lanes with be[i]=1; be=0 performs no RAM write but still acks. A DONE_ADDR write sets done regardless of be.
- Undefined: no be port; every write updates the full word.

Test Plan:
- Reset then read: rst high 2 cycles, then read addr 0x0 with WAIT_CYC=2 -> ack 3 cycles after acceptance, err=0, rdata = preloaded RAM[0]. All outputs are 0 during reset.
- Write/readback: write 0xDEADBEEF to 0x100, then read 0x100 -> rdata=0xDEADBEEF. Check ack spacing of WAIT_CYC+2 with back-to-back req.
- Completion: write 0x7 to 0x50 at cycle 40 -> done rises with ack, done_data=0x7, cyc_cnt frozen at 41. A second write of 0x9 leaves done_data=0x7.
- Errors: write to 0x52 and read of 1<<(AW+2) -> both ack with err=1 and rdata=0; RAM[0x50>>2] unchanged; done stays 0.
- Reset mid-op: assert rst during WAIT of a write to 0x200 -> no ack after release; the following read of 0x200 returns the old value.
- Byte lanes (DMEM_BYTE_EN): RAM[0x10]=0x11223344, write 0xAABBCCDD with be=4'b0101 -> readback 0x11BB33DD.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM behind a req/ack handshake with WAIT_CYC wait states,
// a sticky completion register at DONE_ADDR and a cycle counter. `DMEM_BYTE_EN adds byte-lane write enables.

module dmem_resp_lane #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wd;

  assign rd = mem[idx];
endmodule

module dmem_resp #(
  parameter int                DATA_W    = 32,
  parameter int                AW        = 16,
  parameter int                WAIT_CYC  = 2,
  parameter logic [DATA_W-1:0] DONE_ADDR = 32'h00000050
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [DATA_W-1:0] done_data,
  output logic [DATA_W-1:0] cyc_cnt
);
  localparam int NB = DATA_W / 8;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state, nxt;
  logic [3:0]           cnt;
  req_t                 lat, cur;
  logic [NB-1:0]        be_in;
  logic                 enter, bad, wr, set_done;
  logic [NB-1:0]        lane_we;
  logic [NB-1:0][7:0]   rd_word;

`ifdef DMEM_BYTE_EN
  assign be_in = be;
`else
  assign be_in = '1;
`endif

  // With zero wait states the RAM is hit on the accepting edge, before the latch is loaded.
  always_comb begin
    cur = lat;
    if (state == IDLE) cur = '{we: we, addr: addr, wdata: wdata, be: be_in};
  end

  always_comb begin
    nxt   = state;
    enter = 1'b0;
    case (state)
      IDLE: if (req) begin
        nxt   = (WAIT_CYC == 0) ? RESP : WAIT;
        enter = (WAIT_CYC == 0);
      end
      WAIT: if (cnt == 4'd1) begin
        nxt   = RESP;
        enter = 1'b1;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bad      = (cur.addr[1:0] != 2'b00) || ((cur.addr >> (AW + 2)) != '0);
  assign wr       = enter && cur.we && !bad && !rst;
  assign set_done = wr && (cur.addr == DONE_ADDR) && !done;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_we[i] = wr && cur.be[i];
    dmem_resp_lane #(.AW(AW)) u_lane (
      .clk (clk),
      .we  (lane_we[i]),
      .idx (cur.addr[AW+1:2]),
      .wd  (cur.wdata[8*i +: 8]),
      .rd  (rd_word[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      done      <= 1'b0;
      done_data <= '0;
      cyc_cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        lat <= cur;
        cnt <= 4'(WAIT_CYC);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      ack <= enter;
      err <= enter && bad;
      if (enter) rdata <= bad ? '0 : (cur.we ? rdata : rd_word);
      if (set_done) begin
        done      <= 1'b1;
        done_data <= cur.wdata;
      end
      // The counter freezes on the very edge that raises done.
      if (!done && !set_done) cyc_cnt <= cyc_cnt + 1'b1;
    end
  end
endmodule
